// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage.
// The optional multiply/divide unit is selected by the EX_MULDIV_EN macro.
package ex_pkg;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_RTYPE  = 2'b10,
      ALU_ITYPE  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'b00,
      SRC_B_IMM  = 2'b01,
      SRC_B_FOUR = 2'b10
   } alu_src_b_e;

   typedef enum logic [1:0] {
      FWD_REG    = 2'b00,
      FWD_EX_MEM = 2'b01,
      FWD_MEM_WB = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;
   localparam logic [2:0] F3_BLT     = 3'b100;
   localparam logic [2:0] F3_BGE     = 3'b101;
   localparam logic [2:0] F3_BLTU    = 3'b110;
   localparam logic [2:0] F3_BGEU    = 3'b111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/ex_if.sv
// ID/EX operand bundle, forwarding inputs and EX results.
// master = the pipeline driving ID/EX, slave = the execute stage.
interface ex_if #(parameter int XLEN = 32);
   logic [XLEN-1:0] id_ex_pc_p4;
   logic [XLEN-1:0] id_ex_branch_target;
   logic [6:0]      id_ex_funct7;
   logic [2:0]      id_ex_funct3;
   logic [XLEN-1:0] id_ex_rd1;
   logic [XLEN-1:0] id_ex_rd2;
   logic [XLEN-1:0] id_ex_imm;
   logic            id_ex_branch;
   logic            id_ex_jump;
   logic            id_ex_jump_src;
   logic [1:0]      id_ex_alu_op;
   logic            id_ex_alu_src_a;
   logic [1:0]      id_ex_alu_src_b;
   logic [1:0]      fwd_a_sel;
   logic [1:0]      fwd_b_sel;
   logic [XLEN-1:0] ex_mem_result;
   logic [XLEN-1:0] mem_wb_result;
   logic [XLEN-1:0] ex_result;
   logic [XLEN-1:0] ex_store_data;
   logic            ex_pc_sel;
   logic [XLEN-1:0] ex_pc_target;
   logic            ex_stall;

   modport master (
      output id_ex_pc_p4, id_ex_branch_target, id_ex_funct7, id_ex_funct3,
             id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_branch, id_ex_jump,
             id_ex_jump_src, id_ex_alu_op, id_ex_alu_src_a, id_ex_alu_src_b,
             fwd_a_sel, fwd_b_sel, ex_mem_result, mem_wb_result,
      input  ex_result, ex_store_data, ex_pc_sel, ex_pc_target, ex_stall
   );

   modport slave (
      input  id_ex_pc_p4, id_ex_branch_target, id_ex_funct7, id_ex_funct3,
             id_ex_rd1, id_ex_rd2, id_ex_imm, id_ex_branch, id_ex_jump,
             id_ex_jump_src, id_ex_alu_op, id_ex_alu_src_a, id_ex_alu_src_b,
             fwd_a_sel, fwd_b_sel, ex_mem_result, mem_wb_result,
      output ex_result, ex_store_data, ex_pc_sel, ex_pc_target, ex_stall
   );
endinterface

// File: rtl/ex_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; built only with EX_MULDIV_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// DIV_IDLE  | waiting; start_i raises busy_o in the same cycle
// DIV_BUSY  | one shift-subtract step per cycle on latched magnitudes
// DIV_DONE  | busy_o low, result_o holds the sign-corrected answer
`ifdef EX_MULDIV_EN
module ex_divider
   import ex_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start_i,
   input  logic            signed_i,
   input  logic            rem_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CW = $clog2(DIV_CYCLES);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state_q;
   logic [XLEN-1:0] quot_q, rem_q, divisor_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_quot_q, neg_rem_q, is_rem_q;

   logic [XLEN-1:0] abs_dividend, abs_divisor, quot_final, rem_final;
   logic [XLEN:0]   rem_sh;
   logic            ge;

   assign abs_dividend = (signed_i && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
   assign abs_divisor  = (signed_i && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

   // partial remainder shifted left with the next dividend bit
   assign rem_sh = {rem_q, quot_q[XLEN-1]};
   assign ge     = rem_sh >= {1'b0, divisor_q};

   // divider sequencing; reset abandons any divide in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= DIV_IDLE;
         quot_q     <= '0;
         rem_q      <= '0;
         divisor_q  <= '0;
         cnt_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         is_rem_q   <= 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (start_i) begin
                  is_rem_q <= rem_i;
                  if (divisor_i == '0) begin
                     quot_q     <= '1;
                     rem_q      <= dividend_i;
                     neg_quot_q <= 1'b0;
                     neg_rem_q  <= 1'b0;
                     state_q    <= DIV_DONE;
                  end else if (signed_i && dividend_i == INT_MIN && divisor_i == '1) begin
                     quot_q     <= INT_MIN;
                     rem_q      <= '0;
                     neg_quot_q <= 1'b0;
                     neg_rem_q  <= 1'b0;
                     state_q    <= DIV_DONE;
                  end else begin
                     quot_q     <= abs_dividend;
                     rem_q      <= '0;
                     divisor_q  <= abs_divisor;
                     neg_quot_q <= signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                     neg_rem_q  <= signed_i & dividend_i[XLEN-1];
                     cnt_q      <= CW'(DIV_CYCLES - 1);
                     state_q    <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               quot_q <= {quot_q[XLEN-2:0], ge};
               rem_q  <= ge ? XLEN'(rem_sh - {1'b0, divisor_q}) : rem_sh[XLEN-1:0];
               if (cnt_q == '0) state_q <= DIV_DONE;
               else             cnt_q   <= cnt_q - CW'(1);
            end
            default: state_q <= DIV_IDLE;
         endcase
      end
   end

   // the reset term makes ex_stall fall as soon as rstn goes low
   assign busy_o = rstn & ((state_q == DIV_BUSY) || (state_q == DIV_IDLE && start_i));
   assign done_o = (state_q == DIV_DONE);

   assign quot_final = neg_quot_q ? -quot_q : quot_q;
   assign rem_final  = neg_rem_q  ? -rem_q  : rem_q;
   assign result_o   = is_rem_q ? rem_final : quot_final;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolution and optional mul/div.
// EX_MULDIV_EN builds the RV32M multiplier and the iterative divider;
// without it, M-extension R-type ops return 0 and ex_stall stays low.
module ex_stage
   import ex_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input logic clk,
   input logic rstn,
   ex_if.slave bus
);
   logic [XLEN-1:0] a_fwd, b_fwd, op_a, op_b, alu_res, muldiv_res, div_result;
   logic            is_muldiv, taken, div_sel;

   function automatic logic [XLEN-1:0] alu_core(input logic [2:0] f3, input logic sub,
                                                 input logic arith,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      logic [4:0]      sh;
      sh = b[4:0];
      case (f3)
         F3_ADD_SUB: r = sub ? a - b : a + b;
         F3_SLL:     r = a << sh;
         F3_SLT:     r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         F3_SLTU:    r = {{(XLEN-1){1'b0}}, a < b};
         F3_XOR:     r = a ^ b;
         F3_SRL_SRA: r = arith ? XLEN'($signed(a) >>> sh) : a >> sh;
         F3_OR:      r = a | b;
         default:    r = a & b;
      endcase
      return r;
   endfunction

   // forwarding muxes for rs1/rs2
   always_comb begin
      case (fwd_sel_e'(bus.fwd_a_sel))
         FWD_EX_MEM: a_fwd = bus.ex_mem_result;
         FWD_MEM_WB: a_fwd = bus.mem_wb_result;
         default:    a_fwd = bus.id_ex_rd1;
      endcase
      case (fwd_sel_e'(bus.fwd_b_sel))
         FWD_EX_MEM: b_fwd = bus.ex_mem_result;
         FWD_MEM_WB: b_fwd = bus.mem_wb_result;
         default:    b_fwd = bus.id_ex_rd2;
      endcase
   end

   // ALU operand selection
   always_comb begin
      op_a = bus.id_ex_alu_src_a ? bus.id_ex_pc_p4 - XLEN'(4) : a_fwd;
      case (alu_src_b_e'(bus.id_ex_alu_src_b))
         SRC_B_RS2:  op_b = b_fwd;
         SRC_B_IMM:  op_b = bus.id_ex_imm;
         SRC_B_FOUR: op_b = XLEN'(4);
         default:    op_b = '0;
      endcase
   end

   assign is_muldiv = (bus.id_ex_funct7 == FUNCT7_MULDIV);

   // ALU result; SUB is R-type only, SRA/SRAI both key off funct7[5]
   always_comb begin
      case (alu_op_e'(bus.id_ex_alu_op))
         ALU_ADD:    alu_res = op_a + op_b;
         ALU_BRANCH: alu_res = op_a - op_b;
         ALU_RTYPE:  alu_res = is_muldiv ? muldiv_res
                                         : alu_core(bus.id_ex_funct3, bus.id_ex_funct7[5],
                                                    bus.id_ex_funct7[5], op_a, op_b);
         default:    alu_res = alu_core(bus.id_ex_funct3, 1'b0, bus.id_ex_funct7[5],
                                        op_a, op_b);
      endcase
   end

   // branch comparator on forwarded operands
   always_comb begin
      case (bus.id_ex_funct3)
         F3_BEQ:  taken = (a_fwd == b_fwd);
         F3_BNE:  taken = (a_fwd != b_fwd);
         F3_BLT:  taken = ($signed(a_fwd) < $signed(b_fwd));
         F3_BGE:  taken = !($signed(a_fwd) < $signed(b_fwd));
         F3_BLTU: taken = (a_fwd < b_fwd);
         F3_BGEU: taken = !(a_fwd < b_fwd);
         default: taken = 1'b0;
      endcase
   end

`ifdef EX_MULDIV_EN
   logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
   logic [XLEN-1:0]   mul_res;
   logic              mul_a_signed, mul_b_signed, div_op, div_busy, div_done;

   // MULH signs both operands, MULHSU only rs1; the low half is sign-agnostic
   assign mul_a_signed = (bus.id_ex_funct3[1:0] != 2'b11);
   assign mul_b_signed = (bus.id_ex_funct3[1:0] == 2'b01);
   assign mul_a_ext    = {{XLEN{mul_a_signed & op_a[XLEN-1]}}, op_a};
   assign mul_b_ext    = {{XLEN{mul_b_signed & op_b[XLEN-1]}}, op_b};
   assign mul_prod     = mul_a_ext * mul_b_ext;
   assign mul_res      = (bus.id_ex_funct3[1:0] == 2'b00) ? mul_prod[XLEN-1:0]
                                                          : mul_prod[2*XLEN-1:XLEN];

   assign div_op = (alu_op_e'(bus.id_ex_alu_op) == ALU_RTYPE) & is_muldiv & bus.id_ex_funct3[2];

   ex_divider #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) u_divider (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (div_op),
      .signed_i   (~bus.id_ex_funct3[0]),
      .rem_i      (bus.id_ex_funct3[1]),
      .dividend_i (a_fwd),
      .divisor_i  (b_fwd),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .result_o   (div_result)
   );

   assign muldiv_res   = bus.id_ex_funct3[2] ? div_result : mul_res;
   assign div_sel      = div_done;
   assign bus.ex_stall = div_busy;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rstn;
   assign div_result     = '0;
   assign muldiv_res     = '0;
   assign div_sel        = 1'b0;
   assign bus.ex_stall   = 1'b0;
`endif

   // the DONE cycle presents the divider answer even if ID/EX was flushed
   assign bus.ex_result     = div_sel ? div_result : (bus.id_ex_jump ? bus.id_ex_pc_p4 : alu_res);
   assign bus.ex_store_data = b_fwd;
   assign bus.ex_pc_sel     = bus.id_ex_jump | (bus.id_ex_branch & taken);
   assign bus.ex_pc_target  = bus.id_ex_jump_src
                              ? (a_fwd + bus.id_ex_imm) & {{(XLEN-1){1'b1}}, 1'b0}
                              : bus.id_ex_branch_target;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; divide scenarios follow EX_MULDIV_EN.
module tb_ex_stage;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   ex_if #(.XLEN(32)) bus();
   ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   int errors = 0;
   int checks = 0;

   localparam int K_RES = 0, K_SEL = 1, K_TGT = 2, K_STORE = 3, K_STALL = 4;
   typedef struct { string name; int kind; logic [31:0] val; } exp_t;
   exp_t sb[$];

   typedef struct { string name; logic [1:0] op; logic [6:0] f7; logic [2:0] f3;
                    logic src_a; logic [1:0] src_b; logic [31:0] a, b, imm, pc4, res; } alu_vec_t;
   typedef struct { string name; logic [2:0] f3; logic [31:0] a, b; logic br, jmp, jsrc;
                    logic [31:0] imm; logic sel; logic [31:0] tgt; } br_vec_t;
   typedef struct { string name; logic [2:0] f3; logic [31:0] a, b; int stall;
                    logic [31:0] res; } div_vec_t;

   function automatic logic [31:0] observe(int kind);
      case (kind)
         K_RES:   return bus.ex_result;
         K_SEL:   return {31'b0, bus.ex_pc_sel};
         K_TGT:   return bus.ex_pc_target;
         K_STORE: return bus.ex_store_data;
         default: return {31'b0, bus.ex_stall};
      endcase
   endfunction

   task automatic set_nop();
      bus.id_ex_pc_p4 = '0; bus.id_ex_branch_target = '0; bus.id_ex_funct7 = '0;
      bus.id_ex_funct3 = '0; bus.id_ex_rd1 = '0; bus.id_ex_rd2 = '0; bus.id_ex_imm = '0;
      bus.id_ex_branch = 0; bus.id_ex_jump = 0; bus.id_ex_jump_src = 0;
      bus.id_ex_alu_op = 2'b00; bus.id_ex_alu_src_a = 0; bus.id_ex_alu_src_b = 2'b00;
      bus.fwd_a_sel = 2'b00; bus.fwd_b_sel = 2'b00;
      bus.ex_mem_result = '0; bus.mem_wb_result = '0;
   endtask

   task automatic set_rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a, b);
      set_nop();
      bus.id_ex_alu_op = 2'b10; bus.id_ex_funct7 = f7; bus.id_ex_funct3 = f3;
      bus.id_ex_rd1 = a; bus.id_ex_rd2 = b;
   endtask

   task automatic test_reset();
      exp_t e;
      rstn = 1'b0;
      set_nop();
      #3;
      sb.push_back('{"reset stall", K_STALL, 32'd0});
      sb.push_back('{"reset pc_sel", K_SEL, 32'd0});
      sb.push_back('{"reset result", K_RES, 32'd0});
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_forwarding();
      exp_t e;
      @(posedge clk); #1;
      set_rtype(7'h00, 3'b000, 32'd5, 32'd3);
      bus.ex_mem_result = 32'd7; bus.fwd_a_sel = 2'b01;
      sb.push_back('{"fwd a ex_mem", K_RES, 32'd10});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
      @(posedge clk); #1;
      set_rtype(7'h00, 3'b000, 32'd5, 32'd3);
      bus.mem_wb_result = 32'd20; bus.fwd_b_sel = 2'b10;
      sb.push_back('{"fwd b mem_wb", K_RES, 32'd25});
      sb.push_back('{"fwd b store", K_STORE, 32'd20});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
      @(posedge clk); #1;
      set_rtype(7'h00, 3'b000, 32'd5, 32'd3);
      bus.mem_wb_result = 32'd100; bus.fwd_a_sel = 2'b10;
      bus.ex_mem_result = 32'd1;   bus.fwd_b_sel = 2'b01;
      sb.push_back('{"fwd both", K_RES, 32'd101});
      sb.push_back('{"fwd both store", K_STORE, 32'd1});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
   endtask

   task automatic test_alu();
      alu_vec_t v[$];
      exp_t e;
      v.push_back('{"SUB",   2'b10, 7'h20, 3'd0, 1'b0, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFE});
      v.push_back('{"SLL",   2'b10, 7'h00, 3'd1, 1'b0, 2'b00, 32'd1, 32'h24, 32'd0, 32'd0, 32'h10});
      v.push_back('{"SLT",   2'b10, 7'h00, 3'd2, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1});
      v.push_back('{"SLTU",  2'b10, 7'h00, 3'd3, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0});
      v.push_back('{"XOR",   2'b10, 7'h00, 3'd4, 1'b0, 2'b00, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'hFF00});
      v.push_back('{"SRL",   2'b10, 7'h00, 3'd5, 1'b0, 2'b00, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'h08000000});
      v.push_back('{"SRA",   2'b10, 7'h20, 3'd5, 1'b0, 2'b00, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'hF8000000});
      v.push_back('{"OR",    2'b10, 7'h00, 3'd6, 1'b0, 2'b00, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'hFF});
      v.push_back('{"AND",   2'b10, 7'h00, 3'd7, 1'b0, 2'b00, 32'hFF, 32'h0F, 32'd0, 32'd0, 32'h0F});
      v.push_back('{"ADD",   2'b10, 7'h00, 3'd0, 1'b0, 2'b00, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'h80000000});
      v.push_back('{"ADDI",  2'b11, 7'h7F, 3'd0, 1'b0, 2'b01, 32'd10, 32'd0, 32'hFFFFFFFD, 32'd0, 32'd7});
      v.push_back('{"SRAI",  2'b11, 7'h20, 3'd5, 1'b0, 2'b01, 32'h80000000, 32'd0, 32'h404, 32'd0, 32'hF8000000});
      v.push_back('{"SLTI",  2'b11, 7'h7F, 3'd2, 1'b0, 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0});
      v.push_back('{"AUIPC", 2'b00, 7'h00, 3'd0, 1'b1, 2'b01, 32'd0, 32'd0, 32'h1000, 32'h104, 32'h1100});
      v.push_back('{"PC+4",  2'b00, 7'h00, 3'd0, 1'b1, 2'b10, 32'd0, 32'd0, 32'd0, 32'h200, 32'h200});
`ifdef EX_MULDIV_EN
      v.push_back('{"MUL",    2'b10, 7'h01, 3'd0, 1'b0, 2'b00, 32'd3, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFA});
      v.push_back('{"MULH",   2'b10, 7'h01, 3'd1, 1'b0, 2'b00, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h40000000});
      v.push_back('{"MULHSU", 2'b10, 7'h01, 3'd2, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF});
      v.push_back('{"MULHU",  2'b10, 7'h01, 3'd3, 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFE});
`else
      v.push_back('{"MUL off", 2'b10, 7'h01, 3'd0, 1'b0, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0});
`endif
      foreach (v[i]) begin
         @(posedge clk); #1;
         set_nop();
         bus.id_ex_alu_op = v[i].op; bus.id_ex_funct7 = v[i].f7; bus.id_ex_funct3 = v[i].f3;
         bus.id_ex_alu_src_a = v[i].src_a; bus.id_ex_alu_src_b = v[i].src_b;
         bus.id_ex_rd1 = v[i].a; bus.id_ex_rd2 = v[i].b; bus.id_ex_imm = v[i].imm;
         bus.id_ex_pc_p4 = v[i].pc4;
         sb.push_back('{v[i].name, K_RES, v[i].res});
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (observe(e.kind) !== e.val) begin
               errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
            end
         end
      end
   endtask

   task automatic test_branch();
      br_vec_t v[$];
      exp_t e;
      v.push_back('{"BLT",      3'd4, 32'hFFFFFFFF, 32'd1, 1, 0, 0, 32'd0, 1'b1, 32'h2000});
      v.push_back('{"BLTU",     3'd6, 32'hFFFFFFFF, 32'd1, 1, 0, 0, 32'd0, 1'b0, 32'h2000});
      v.push_back('{"BEQ",      3'd0, 32'd5, 32'd5, 1, 0, 0, 32'd0, 1'b1, 32'h2000});
      v.push_back('{"BNE",      3'd1, 32'd5, 32'd5, 1, 0, 0, 32'd0, 1'b0, 32'h2000});
      v.push_back('{"BGE",      3'd5, 32'd1, 32'd1, 1, 0, 0, 32'd0, 1'b1, 32'h2000});
      v.push_back('{"BGEU",     3'd7, 32'd1, 32'hFFFFFFFF, 1, 0, 0, 32'd0, 1'b0, 32'h2000});
      v.push_back('{"no branch",3'd4, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0, 1'b0, 32'h2000});
      v.push_back('{"JALR",     3'd0, 32'h1001, 32'd0, 0, 1, 1, 32'd4, 1'b1, 32'h1004});
      v.push_back('{"JAL",      3'd0, 32'h1001, 32'd0, 0, 1, 0, 32'd4, 1'b1, 32'h2000});
      foreach (v[i]) begin
         @(posedge clk); #1;
         set_nop();
         bus.id_ex_alu_op = v[i].jmp ? 2'b00 : 2'b01;
         bus.id_ex_funct3 = v[i].f3; bus.id_ex_rd1 = v[i].a; bus.id_ex_rd2 = v[i].b;
         bus.id_ex_branch = v[i].br; bus.id_ex_jump = v[i].jmp; bus.id_ex_jump_src = v[i].jsrc;
         bus.id_ex_imm = v[i].imm; bus.id_ex_pc_p4 = 32'h104; bus.id_ex_branch_target = 32'h2000;
         sb.push_back('{{v[i].name, " pc_sel"}, K_SEL, {31'b0, v[i].sel}});
         sb.push_back('{{v[i].name, " target"}, K_TGT, v[i].tgt});
         if (v[i].jmp) sb.push_back('{{v[i].name, " link"}, K_RES, 32'h104});
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (observe(e.kind) !== e.val) begin
               errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
            end
         end
      end
   endtask

`ifdef EX_MULDIV_EN
   task automatic test_divide();
      div_vec_t v[$];
      exp_t e;
      int n;
      bit done;
      logic [31:0] got;
      v.push_back('{"DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD});
      v.push_back('{"REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF});
      v.push_back('{"DIV 7/-2",      3'b100, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD});
      v.push_back('{"REM 7/-2",      3'b110, 32'd7, 32'hFFFFFFFE, 33, 32'd1});
      v.push_back('{"DIVU big",      3'b101, 32'hFFFFFFFF, 32'd16, 33, 32'h0FFFFFFF});
      v.push_back('{"DIVU 10/0",     3'b101, 32'd10, 32'd0, 1, 32'hFFFFFFFF});
      v.push_back('{"REM -7/0",      3'b110, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9});
      v.push_back('{"REM min/-1",    3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0});
      v.push_back('{"DIV min/-1",    3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000});
      foreach (v[i]) begin
         @(posedge clk); #1;
         set_rtype(7'h01, v[i].f3, v[i].a, v[i].b);
         sb.push_back('{{v[i].name, " stall cycles"}, K_STALL, 32'(v[i].stall)});
         sb.push_back('{{v[i].name, " result"}, K_RES, v[i].res});
         n = 0; done = 0; got = '0;
         for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.ex_stall === 1'b1) begin
               n++;
               if (c == 3) begin
                  bus.id_ex_rd1 = 32'h12345678; bus.id_ex_rd2 = 32'd3;
               end
            end else begin
               done = 1; got = bus.ex_result;
            end
         end
         checks++;
         if (!done) begin
            errors++; $display("FAIL %s timeout: stall still %b expected 0", v[i].name, bus.ex_stall);
            sb.delete();
         end else begin
            e = sb.pop_front(); checks++;
            if (32'(n) !== e.val) begin
               errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
            end
            e = sb.pop_front();
            if (got !== e.val) begin
               errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
         end
         @(posedge clk); #1;
         set_nop();
      end
   endtask

   task automatic test_back_to_back();
      div_vec_t v[$];
      exp_t e;
      int n;
      bit done;
      logic [31:0] got;
      v.push_back('{"b2b DIVU 100/7", 3'b101, 32'd100, 32'd7, 33, 32'd14});
      v.push_back('{"b2b REMU 100/7", 3'b111, 32'd100, 32'd7, 33, 32'd2});
      @(posedge clk);
      foreach (v[i]) begin
         #1;
         set_rtype(7'h01, v[i].f3, v[i].a, v[i].b);
         sb.push_back('{{v[i].name, " stall cycles"}, K_STALL, 32'(v[i].stall)});
         sb.push_back('{{v[i].name, " result"}, K_RES, v[i].res});
         n = 0; done = 0; got = '0;
         for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.ex_stall === 1'b1) n++;
            else begin done = 1; got = bus.ex_result; end
         end
         checks++;
         if (!done) begin
            errors++; $display("FAIL %s timeout: stall still %b expected 0", v[i].name, bus.ex_stall);
            sb.delete();
         end else begin
            e = sb.pop_front(); checks++;
            if (32'(n) !== e.val) begin
               errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
            end
            e = sb.pop_front();
            if (got !== e.val) begin
               errors++; $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
         end
         @(posedge clk);
      end
      #1;
      set_nop();
   endtask

   task automatic test_flush_done();
      exp_t e;
      @(posedge clk); #1;
      set_rtype(7'h01, 3'b101, 32'd10, 32'd0);
      sb.push_back('{"flush start stall", K_STALL, 32'd1});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
      @(posedge clk); #1;
      set_nop();
      sb.push_back('{"flush done stall", K_STALL, 32'd0});
      sb.push_back('{"flush done result", K_RES, 32'hFFFFFFFF});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
      sb.push_back('{"after flush stall", K_STALL, 32'd0});
      sb.push_back('{"after flush result", K_RES, 32'd0});
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
   endtask

   task automatic test_reset_mid_div();
      exp_t e;
      @(posedge clk); #1;
      set_rtype(7'h01, 3'b100, 32'hFFFFFFF9, 32'd2);
      repeat (11) @(negedge clk);
      sb.push_back('{"mid div stall", K_STALL, 32'd1});
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
      #1 rstn = 1'b0;
      #1;
      sb.push_back('{"async reset stall", K_STALL, 32'd0});
      while (sb.size() > 0) begin
         e = sb.pop_front(); checks++;
         if (observe(e.kind) !== e.val) begin
            errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
         end
      end
      set_rtype(7'h00, 3'b000, 32'd1, 32'd2);
      @(negedge clk); rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sb.push_back('{"post reset stall", K_STALL, 32'd0});
         sb.push_back('{"post reset add", K_RES, 32'd3});
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front(); checks++;
            if (observe(e.kind) !== e.val) begin
               errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
            end
         end
      end
      set_nop();
   endtask
`else
   task automatic test_no_muldiv();
      exp_t e;
      int n;
      @(posedge clk); #1;
      set_rtype(7'h01, 3'b100, 32'd10, 32'd2);
      sb.push_back('{"no-muldiv stall cycles", K_STALL, 32'd0});
      sb.push_back('{"no-muldiv DIV result", K_RES, 32'd0});
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ex_stall !== 1'b0) n++;
      end
      e = sb.pop_front(); checks++;
      if (32'(n) !== e.val) begin
         errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
      end
      e = sb.pop_front(); checks++;
      if (observe(e.kind) !== e.val) begin
         errors++; $display("FAIL %s: got %h expected %h", e.name, observe(e.kind), e.val);
      end
      @(posedge clk); #1;
      set_nop();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_forwarding();
      test_alu();
      test_branch();
`ifdef EX_MULDIV_EN
      test_divide();
      test_back_to_back();
      test_flush_done();
      test_reset_mid_div();
`else
      test_no_muldiv();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
